// File: rtl/spread_stats.sv
// spread_stats: min/max/avg/last over windows of 2^LOG2_WIN accepted spread samples,
// published through a valid/ready hold register. Define SPREAD_STATS_ALERT_EN to add the alert output.
module spread_stats #(
  parameter int unsigned LOG2_WIN = 3
`ifdef SPREAD_STATS_ALERT_EN
  , parameter logic [7:0] ALERT_THRESH = 8'd200
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic                enable_count,
  input  logic [7:0]          spread_in,
  input  logic                stats_ready,
  output logic                stats_valid,
  output logic [7:0]          stat_min,
  output logic [7:0]          stat_max,
  output logic [7:0]          stat_avg,
  output logic [7:0]          stat_last,
  output logic [LOG2_WIN-1:0] sample_count,
  output logic                overrun
`ifdef SPREAD_STATS_ALERT_EN
  , output logic              alert
`endif
);

  localparam int unsigned SUM_W = 8 + LOG2_WIN;

  typedef enum logic {EMPTY, HELD} pub_state_e;

  pub_state_e          state_q, state_d;
  logic [7:0]          acc_min_q, acc_min_d, acc_max_q, acc_max_d;
  logic [SUM_W-1:0]    acc_sum_q, acc_sum_d;
  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [7:0]          min_q, min_d, max_q, max_d, avg_q, avg_d, last_q, last_d;
  logic                overrun_q, overrun_d;

  logic accept, first, close, handshake;

  assign accept    = sample_valid && enable_count;
  assign first     = (cnt_q == '0);
  assign close     = accept && (cnt_q == {LOG2_WIN{1'b1}});
  assign handshake = (state_q == HELD) && stats_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    acc_sum_d = acc_sum_q;
    cnt_d     = cnt_q;
    if (accept) begin
      if (first) begin
        acc_min_d = spread_in;
        acc_max_d = spread_in;
        acc_sum_d = SUM_W'(spread_in);
      end else begin
        acc_min_d = (spread_in < acc_min_q) ? spread_in : acc_min_q;
        acc_max_d = (spread_in > acc_max_q) ? spread_in : acc_max_q;
        acc_sum_d = acc_sum_q + SUM_W'(spread_in);
      end
      cnt_d = cnt_q + LOG2_WIN'(1);
    end
  end

  // Closing results include the closing sample, so they come from the _d side.
  always_comb begin
    min_d     = min_q;
    max_d     = max_q;
    avg_d     = avg_q;
    last_d    = last_q;
    overrun_d = overrun_q;
    if (close) begin
      min_d  = acc_min_d;
      max_d  = acc_max_d;
      avg_d  = acc_sum_d[SUM_W-1 -: 8];
      last_d = spread_in;
      if ((state_q == HELD) && !stats_ready) overrun_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (close) state_d = HELD;
      HELD:  if (!close && stats_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    stats_valid = (state_q == HELD);
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      acc_min_q <= '0;
      acc_max_q <= '0;
      acc_sum_q <= '0;
      cnt_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      avg_q     <= '0;
      last_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      acc_sum_q <= acc_sum_d;
      cnt_q     <= cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      avg_q     <= avg_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  assign stat_min     = min_q;
  assign stat_max     = max_q;
  assign stat_avg     = avg_q;
  assign stat_last    = last_q;
  assign sample_count = cnt_q;
  assign overrun      = overrun_q;

`ifdef SPREAD_STATS_ALERT_EN
  logic alert_q, alert_d;

  // A fresh over-threshold sample wins over a handshake on the same edge.
  always_comb begin
    alert_d = alert_q;
    if (handshake) alert_d = 1'b0;
    if (accept && (spread_in > ALERT_THRESH)) alert_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) alert_q <= 1'b0;
    else       alert_q <= alert_d;
  end

  assign alert = alert_q;
`endif

endmodule

// File: tb/tb_spread_stats.sv
// Scoreboard bench for spread_stats (LOG2_WIN=2): directed cases plus random traffic,
// expected results computed from plain window arithmetic and checked on each handshake.
module tb_spread_stats;

  localparam int unsigned L = 2;
  localparam int unsigned N = 1 << L;

  logic         clk = 1'b0;
  logic         reset;
  logic         sample_valid, enable_count, stats_ready;
  logic [7:0]   spread_in;
  logic         stats_valid;
  logic [7:0]   stat_min, stat_max, stat_avg, stat_last;
  logic [L-1:0] sample_count;
  logic         overrun;
`ifdef SPREAD_STATS_ALERT_EN
  logic         alert;
`endif

  spread_stats #(.LOG2_WIN(L)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .enable_count (enable_count),
    .spread_in    (spread_in),
    .stats_ready  (stats_ready),
    .stats_valid  (stats_valid),
    .stat_min     (stat_min),
    .stat_max     (stat_max),
    .stat_avg     (stat_avg),
    .stat_last    (stat_last),
    .sample_count (sample_count),
    .overrun      (overrun)
`ifdef SPREAD_STATS_ALERT_EN
    , .alert      (alert)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int mn;
    int mx;
    int avg;
    int last;
    int ov;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: samples of the open window, pending result, sticky overrun.
  int   win[$];
  bit   m_held;
  bit   m_ov;
  exp_t m_res;
  exp_t mon_e;

  task automatic check(string name, int act, int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_step(bit sv, bit en, int d, bit rdy);
    exp_t r;
    exp_t nr;
    bit   hs;
    bit   closed;
    int   mn, mx, sum;
    hs     = m_held && rdy;
    closed = 1'b0;
    if (hs) begin
      r     = m_res;
      r.ov  = int'(m_ov);
      r.cnt = win.size();
      exp_q.push_back(r);
    end
    if (sv && en) begin
      win.push_back(d);
      if (win.size() == N) begin
        mn = 255; mx = 0; sum = 0;
        foreach (win[i]) begin
          if (win[i] < mn) mn = win[i];
          if (win[i] > mx) mx = win[i];
          sum += win[i];
        end
        nr.mn   = mn;
        nr.mx   = mx;
        nr.avg  = sum / N;
        nr.last = win[N-1];
        nr.ov   = 0;
        nr.cnt  = 0;
        closed  = 1'b1;
        win.delete();
      end
    end
    if (closed) begin
      if (m_held && !rdy) m_ov = 1'b1;
      m_held = 1'b1;
      m_res  = nr;
    end else if (hs) begin
      m_held = 1'b0;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the model tracks the same cycle.
  task automatic step(bit sv, bit en, int d, bit rdy);
    @(posedge clk);
    #1;
    sample_valid = sv;
    enable_count = en;
    spread_in    = 8'(d);
    stats_ready  = rdy;
    model_step(sv, en, d, rdy);
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_valid"}, int'(stats_valid), 0);
    check({tag, "_min"},   int'(stat_min), 0);
    check({tag, "_max"},   int'(stat_max), 0);
    check({tag, "_avg"},   int'(stat_avg), 0);
    check({tag, "_last"},  int'(stat_last), 0);
    check({tag, "_count"}, int'(sample_count), 0);
    check({tag, "_ovr"},   int'(overrun), 0);
  endtask

  task automatic do_reset(string tag);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    enable_count = 1'b0;
    stats_ready  = 1'b0;
    spread_in    = 8'd0;
    reset        = 1'b1;
    #1;
    check_zero_outputs(tag);
    check({tag, "_pending"}, exp_q.size(), 0);
    win.delete();
    m_held = 1'b0;
    m_ov   = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_result(string tag, int mn, int mx, int avg, int last, int ov);
    check({tag, "_valid"}, int'(stats_valid), 1);
    check({tag, "_min"},   int'(stat_min), mn);
    check({tag, "_max"},   int'(stat_max), mx);
    check({tag, "_avg"},   int'(stat_avg), avg);
    check({tag, "_last"},  int'(stat_last), last);
    check({tag, "_ovr"},   int'(overrun), ov);
  endtask

  // Monitor: every handshake the DUT presents must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset && stats_valid && stats_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL hs_unexpected: got a handshake with min=%0d max=%0d, expected no pending result at %0t",
                 stat_min, stat_max, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("hs_min",   int'(stat_min), mon_e.mn);
        check("hs_max",   int'(stat_max), mon_e.mx);
        check("hs_avg",   int'(stat_avg), mon_e.avg);
        check("hs_last",  int'(stat_last), mon_e.last);
        check("hs_ovr",   int'(overrun), mon_e.ov);
        check("hs_count", int'(sample_count), mon_e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected $finish before %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    enable_count = 1'b0;
    stats_ready  = 1'b0;
    spread_in    = 8'd0;
    m_held       = 1'b0;
    m_ov         = 1'b0;
    do_reset("rst0");

    // Valid samples with counting disabled change nothing.
    repeat (6) step(1, 0, 77, 0);
    step(0, 0, 0, 0);
    check("noen_count", int'(sample_count), 0);
    check("noen_valid", int'(stats_valid), 0);

    // Basic window, then an unconsumed result overwritten by a second window.
    step(1, 1, 5, 0); step(1, 1, 9, 0); step(1, 1, 3, 0); step(1, 1, 7, 0);
    step(0, 0, 0, 0);
    check_result("win1", 3, 9, 6, 7, 0);
    check("win1_count", int'(sample_count), 0);
    step(1, 1, 10, 0); step(1, 1, 10, 0); step(1, 1, 10, 0); step(1, 1, 11, 0);
    step(0, 0, 0, 0);
    check_result("ovw", 10, 11, 10, 11, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("ovw_after_valid", int'(stats_valid), 0);
    check("ovw_sticky", int'(overrun), 1);

    // Close on the same edge as a handshake: stays valid, no overrun.
    do_reset("rst1");
    step(1, 1, 5, 0); step(1, 1, 9, 0); step(1, 1, 3, 0); step(1, 1, 7, 0);
    step(1, 1, 20, 0); step(1, 1, 30, 0); step(1, 1, 40, 0); step(1, 1, 50, 1);
    step(0, 0, 0, 0);
    check_result("samehs", 20, 50, 35, 50, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Reset mid-window discards the partial window.
    step(1, 1, 100, 0); step(1, 1, 250, 0);
    step(0, 0, 0, 0);
    check("mid_count", int'(sample_count), 2);
    do_reset("rst2");
    step(1, 1, 1, 0); step(1, 1, 2, 0); step(1, 1, 3, 0); step(1, 1, 4, 0);
    step(0, 0, 0, 0);
    check_result("afterrst", 1, 4, 2, 4, 0);
    step(0, 0, 0, 1);

    // Random traffic with extreme values mixed in.
    for (int i = 0; i < 600; i++) begin
      int d;
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      d = 0;
      else if (sel == 1) d = 255;
      else               d = int'($urandom_range(0, 255));
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8), d, ($urandom_range(0, 9) < 3));
    end

    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("drain_pending", exp_q.size(), 0);
    check("drain_valid", int'(stats_valid), 0);
    check("drain_ovr", int'(overrun), int'(m_ov));
    check("drain_count", int'(sample_count), win.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
